// File: rtl/masked_ram_1r1w_clr.sv
// masked_ram_1r1w_clr
// Single-clock 1R1W RAM model with byte-lane write mask, hardware clear FSM,
// selectable read-during-write policy, optional output stage and read-valid.
//
// Optional feature macro: RAM_PARITY_EN
//   Defined   -> one even-parity bit per byte lane is stored on write and
//                checked on read; mismatches appear on R0_perr.
//   Undefined -> no parity storage, no R0_perr port.
//
// Ports:
//   clock              single clock
//   reset_n            asynchronous active-low reset (starts a clear)
//   W0_addr/en/data/mask  write port, mask bit i covers data[8i+7:8i]
//   R0_addr/en         read request
//   R0_data/R0_valid   read result and its one-cycle valid strobe
//   clr_req            pulse that starts a full-array clear
//   init_busy          clear in progress, host accesses ignored
//   R0_perr            per-lane parity error (RAM_PARITY_EN only)
module masked_ram_1r1w_clr #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MASK_W  = 4,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid,
  input  logic              clr_req,
  output logic              init_busy
`ifdef RAM_PARITY_EN
  ,
  output logic [MASK_W-1:0] R0_perr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_next_s;
  logic              init_busy_r;
  logic              accept_s;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [MASK_W-1:0] wr_mask_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] old_word_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              hit_s;

  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

`ifdef RAM_PARITY_EN
  logic [MASK_W-1:0] par_r [DEPTH];
  logic [MASK_W-1:0] wr_par_s;
  logic [MASK_W-1:0] perr_s;
  logic [MASK_W-1:0] rd_perr_r;

  // Even parity per byte lane: bit i is the XOR of byte i.
  function automatic logic [MASK_W-1:0] lane_parity(input logic [DATA_W-1:0] d);
    logic [MASK_W-1:0] p;
    p = '0;
    for (int i = 0; i < MASK_W; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction
`endif

  assign accept_s  = (state_r == ST_IDLE);
  assign init_busy = init_busy_r;

  // FSM state, clear counter and registered busy flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= '0;
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      clr_cnt_r   <= clr_cnt_next_s;
      init_busy_r <= (state_next_s == ST_CLEAR);
    end
  end

  // FSM next-state: IDLE waits for clr_req, CLEAR sweeps every entry once
  always_comb begin
    state_next_s   = state_r;
    clr_cnt_next_s = clr_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_next_s   = ST_CLEAR;
          clr_cnt_next_s = '0;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == {ADDR_W{1'b1}}) begin
          state_next_s   = ST_IDLE;
          clr_cnt_next_s = '0;
        end else begin
          clr_cnt_next_s = clr_cnt_r + ADDR_W'(1'b1);
        end
      end
      default: begin
        state_next_s   = ST_CLEAR;
        clr_cnt_next_s = '0;
      end
    endcase
  end

  // Write-port mux: the clear sweep owns the port while busy
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = W0_addr;
    wr_data_s = W0_data;
    wr_mask_s = W0_mask;
    if (state_r == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_cnt_r;
      wr_data_s = '0;
      wr_mask_s = '1;
    end else begin
      wr_en_s   = W0_en;
    end
  end

`ifdef RAM_PARITY_EN
  assign wr_par_s = lane_parity(wr_data_s);
`endif

  // Array write with per-lane enables (contents are never reset directly)
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wr_mask_s[i]) begin
          mem_r[wr_addr_s][8*i +: 8] <= wr_data_s[8*i +: 8];
`ifdef RAM_PARITY_EN
          par_r[wr_addr_s][i]        <= wr_par_s[i];
`endif
        end
      end
    end
  end

  // Read word: colliding masked lanes are forwarded only when BYPASS is set
  always_comb begin
    old_word_s = mem_r[R0_addr];
    hit_s      = (BYPASS != 0) && accept_s && W0_en && (W0_addr == R0_addr);
    rd_word_s  = old_word_s;
`ifdef RAM_PARITY_EN
    perr_s     = '0;
`endif
    for (int i = 0; i < MASK_W; i++) begin
      if (hit_s && W0_mask[i]) begin
        rd_word_s[8*i +: 8] = W0_data[8*i +: 8];
`ifdef RAM_PARITY_EN
        perr_s[i]           = 1'b0;
`endif
      end else begin
        rd_word_s[8*i +: 8] = old_word_s[8*i +: 8];
`ifdef RAM_PARITY_EN
        perr_s[i]           = (^old_word_s[8*i +: 8]) ^ par_r[R0_addr][i];
`endif
      end
    end
  end

  // First read stage: capture on accepted read, otherwise hold
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
`ifdef RAM_PARITY_EN
      rd_perr_r  <= '0;
`endif
    end else begin
      rd_valid_r <= accept_s && R0_en;
      if (accept_s && R0_en) begin
        rd_data_r <= rd_word_s;
`ifdef RAM_PARITY_EN
        rd_perr_r <= perr_s;
`endif
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out_data_r;
      logic              out_valid_r;
`ifdef RAM_PARITY_EN
      logic [MASK_W-1:0] out_perr_r;
`endif
      // Second read stage: delays data and valid together, holds otherwise
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          out_data_r  <= '0;
          out_valid_r <= 1'b0;
`ifdef RAM_PARITY_EN
          out_perr_r  <= '0;
`endif
        end else begin
          out_valid_r <= rd_valid_r;
          if (rd_valid_r) begin
            out_data_r <= rd_data_r;
`ifdef RAM_PARITY_EN
            out_perr_r <= rd_perr_r;
`endif
          end
        end
      end
      assign R0_data  = out_data_r;
      assign R0_valid = out_valid_r;
`ifdef RAM_PARITY_EN
      assign R0_perr  = out_perr_r;
`endif
    end else begin : g_no_out_reg
      assign R0_data  = rd_data_r;
      assign R0_valid = rd_valid_r;
`ifdef RAM_PARITY_EN
      assign R0_perr  = rd_perr_r;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_masked_ram_1r1w_clr.sv
module tb_masked_ram_1r1w_clr;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = 4;
  localparam int OUT_REG_P = 0;
  localparam int BYPASS_P  = 1;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [DATA_W-1:0] R0_data;
  logic              R0_valid;
  logic              clr_req;
  logic              init_busy;
`ifdef RAM_PARITY_EN
  logic [MASK_W-1:0] R0_perr;
`endif

  masked_ram_1r1w_clr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MASK_W (MASK_W),
    .OUT_REG(OUT_REG_P),
    .BYPASS (BYPASS_P)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .W0_addr  (W0_addr),
    .W0_en    (W0_en),
    .W0_data  (W0_data),
    .W0_mask  (W0_mask),
    .R0_addr  (R0_addr),
    .R0_en    (R0_en),
    .R0_data  (R0_data),
    .R0_valid (R0_valid),
    .clr_req  (clr_req),
    .init_busy(init_busy)
`ifdef RAM_PARITY_EN
    ,
    .R0_perr  (R0_perr)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] perr;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every R0_valid pops one expected result and checks data and timing
  always @(negedge clock) begin
    if (reset_n && R0_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got R0_data 0x%08h with no read outstanding (cycle %0d)", R0_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", R0_data, e.data);
        chk("rd_cycle", cyc, e.cyc);
`ifdef RAM_PARITY_EN
        chk("rd_perr", 32'(R0_perr), 32'(e.perr));
`endif
      end
    end
  end

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] p);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.cyc  = cyc + 1 + OUT_REG_P;
    sb.push_back(e);
  endtask

  // Issue one read this cycle; caller decides whether R0_en stays high
  task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    R0_en   = 1'b1;
    R0_addr = a;
    push_exp(d, 4'b0000);
    @(negedge clock);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
    W0_en   = 1'b1;
    W0_addr = a;
    W0_data = d;
    W0_mask = m;
    @(negedge clock);
    W0_en   = 1'b0;
  endtask

  // Counts busy cycles of a clear; optionally pokes a write and/or resets mid-clear
  task automatic run_clear(input int wr_at, input int rst_at, input int rd_until);
    int n;
    int rst_left;
    n = 0;
    rst_left = rst_at;
    while (init_busy && n < 2000) begin
      R0_en   = (n < rd_until);
      R0_addr = 9'h001;
      W0_en   = (n == wr_at);
      W0_addr = 9'h001;
      W0_data = 32'hFFFF_FFFF;
      W0_mask = 4'hF;
      if (n == rst_left) begin
        R0_en    = 1'b0;
        W0_en    = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("midclr_rst_busy", 32'(init_busy), 32'd1);
        chk("midclr_rst_valid", 32'(R0_valid), 32'd0);
        chk("midclr_rst_data", R0_data, 32'h0000_0000);
        @(negedge clock);
        reset_n  = 1'b1;
        rst_left = -1;
        n = 0;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    R0_en = 1'b0;
    W0_en = 1'b0;
    chk("clear_cycles", n, 512);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    W0_addr = '0; W0_en = 1'b0; W0_data = '0; W0_mask = '0;
    R0_addr = '0; R0_en = 1'b0; clr_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_data", R0_data, 32'h0000_0000);
    chk("rst_valid", 32'(R0_valid), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    reset_n = 1'b1;

    // Power-on clear with reads and a write attempted while busy
    run_clear(2, -1, 100);
    chk("idle_busy", 32'(init_busy), 32'd0);

    issue_read(9'h000, 32'h0000_0000);
    issue_read(9'h1FF, 32'h0000_0000);
    issue_read(9'h001, 32'h0000_0000);
    R0_en = 1'b0;

    // Masked writes
    do_write(9'h010, 32'hDEAD_BEEF, 4'hF);
    do_write(9'h010, 32'h1122_3344, 4'h5);
    issue_read(9'h010, 32'hDE22_BE44);
    R0_en = 1'b0;

    // Mask 0 leaves the entry untouched
    do_write(9'h030, 32'h1234_5678, 4'hF);
    do_write(9'h030, 32'hFFFF_FFFF, 4'h0);
    issue_read(9'h030, 32'h1234_5678);
    R0_en = 1'b0;

    // Same-address read during write
    do_write(9'h020, 32'hAAAA_AAAA, 4'hF);
    W0_en = 1'b1; W0_addr = 9'h020; W0_data = 32'h5555_5555; W0_mask = 4'h3;
    issue_read(9'h020, (BYPASS_P != 0) ? 32'hAAAA_5555 : 32'hAAAA_AAAA);
    W0_en = 1'b0;
    issue_read(9'h020, 32'hAAAA_5555);
    R0_en = 1'b0;

    // Different addresses on the same edge are independent
    W0_en = 1'b1; W0_addr = 9'h040; W0_data = 32'hCAFE_F00D; W0_mask = 4'hF;
    issue_read(9'h030, 32'h1234_5678);
    W0_en = 1'b0;

    // Back-to-back reads, one per cycle
    issue_read(9'h040, 32'hCAFE_F00D);
    issue_read(9'h010, 32'hDE22_BE44);
    issue_read(9'h020, 32'hAAAA_5555);
    issue_read(9'h030, 32'h1234_5678);
    R0_en = 1'b0;

    // Hold: output keeps the last result after the entry is overwritten
    issue_read(9'h010, 32'hDE22_BE44);
    R0_en = 1'b0;
    do_write(9'h010, 32'h0000_0000, 4'hF);
    repeat (3) @(negedge clock);
    chk("hold_data", R0_data, 32'hDE22_BE44);
    chk("hold_valid", 32'(R0_valid), 32'd0);
    issue_read(9'h010, 32'h0000_0000);
    R0_en = 1'b0;

`ifdef RAM_PARITY_EN
    // Corrupted stored parity on lane 2 is reported on read
    do_write(9'h060, 32'h0102_0304, 4'hF);
    force dut.par_r[96] = 4'b1001;
    R0_en = 1'b1;
    R0_addr = 9'h060;
    push_exp(32'h0102_0304, 4'b0100);
    @(negedge clock);
    R0_en = 1'b0;
    repeat (3) @(negedge clock);
    release dut.par_r[96];
`endif

    // Fill some entries, then clear on request with a mid-clear write
    do_write(9'h150, 32'h0BAD_CAFE, 4'hF);
    do_write(9'h1FF, 32'hFEED_FACE, 4'hF);
    do_write(9'h001, 32'h7777_7777, 4'hF);
    issue_read(9'h1FF, 32'hFEED_FACE);
    R0_en = 1'b0;
    repeat (3) @(negedge clock);
    clr_req = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    chk("clr_busy", 32'(init_busy), 32'd1);
    run_clear(3, -1, 50);
    issue_read(9'h001, 32'h0000_0000);
    issue_read(9'h150, 32'h0000_0000);
    R0_en = 1'b0;

    // Clear interrupted by reset restarts from entry 0
    do_write(9'h002, 32'h1357_9BDF, 4'hF);
    do_write(9'h1F0, 32'h2468_ACE0, 4'hF);
    clr_req = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    run_clear(3, 100, 0);

    // Whole array reads zero afterwards
    for (int a = 0; a < 512; a++) begin
      issue_read(9'(a), 32'h0000_0000);
    end
    R0_en = 1'b0;

    repeat (5) @(negedge clock);
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
